pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
Program-counter generator at the front of the RV32IM fetch stage. Holds the current fetch address on pc_o and advances it by 4 per accepted handshake, or redirects it to a branch/jump target. Updates only when the downstream fetch stage asserts ready_i, so pipeline stalls freeze the PC.

Parameters:
BOOT_ADDR, 32'h0000_0000, PC value loaded on reset (fetch start address); full 32 bits used.

Ports:
clk_i  input  1  single system clock, all state updates on rising edge
rst_i  input  1  asynchronous, active-high reset
ready_i  input  1  downstream fetch stage accepts the current PC; enables PC update this edge
valid_o  output  1  pc_o holds a valid fetch address
branch_taken_i  input  1  redirect request; selects branch_target_addr_i as next PC
branch_target_addr_i  input  32  redirect target address
pc_o  output  32  current fetch address (registered)

Behaviour:
- Clocking/reset: one clock (clk_i); reset is asynchronous and active-high (rst_i).
- Reset: while rst_i=1, pc_o=BOOT_ADDR and valid_o=0 immediately, independent of the clock.
- After reset release, pc_o stays BOOT_ADDR until the first edge with ready_i=1.
- valid_o is a register cleared by reset and set to 1 on every rising edge with rst_i=0. It stays 1 until the next reset.
- Next-PC selection on each rising edge, priority high to low:
  1. rst_i=1 -> BOOT_ADDR.
  2. ready_i=0 -> hold pc_o. A branch presented this cycle is ignored: not latched, not queued.
  3. ready_i=1 and branch_taken_i=1 -> pc_o <= branch_target_addr_i.
  4. ready_i=1 and branch_taken_i=0 -> pc_o <= pc_o + 4.
- Latency: one cycle. A redirect is visible on pc_o after the edge where branch_taken_i and ready_i are both 1.
- Sequential fetch continues from the new target on following edges (target, target+4, ...).
- Arithmetic: 32-bit unsigned add, modulo 2^32. 0xFFFF_FFFC + 4 -> 0x0000_0000, no flag, no saturation.
- No alignment enforcement by default. The target is loaded verbatim, e.g. 0xAAAA_BBBB is loaded unchanged.
- Simultaneous branch_taken_i and stall (ready_i=0): PC holds. If both inputs are still asserted when ready_i rises, the branch executes on that edge.
- Reset asserted mid-operation overrides everything asynchronously. Normal operation resumes on the next edges after release.
- No combinational path from inputs to pc_o or valid_o; both outputs are registered.

Optional Feature:
Macro PC_ALIGN_EN.
- Defined: the redirect target has bits [1:0] forced to 0 before loading. 0xAAAA_BBBB loads as 0xAAAA_BBB8. BOOT_ADDR and the +4 path are unchanged.
- Undefined: the target is loaded verbatim (default behaviour above).

Test Plan:
- Reset with BOOT_ADDR=0x8000_0000, ready_i=0, 2 cycles, then release -> pc_o=0x8000_0000; valid_o=0 during reset and 1 after the first edge out of reset.
- ready_i=1 for 2 edges, no branch -> pc_o=0x8000_0004, then 0x8000_0008.
- ready_i=0 for 2 edges -> pc_o held at 0x8000_0008 on both edges.
- ready_i=1, branch_taken_i=1, target=0x9000_0000 for 1 edge, then branch_taken_i=0 for 1 edge -> pc_o=0x9000_0000, then 0x9000_0004.
- ready_i=0, branch_taken_i=1, target=0xAAAA_BBBB for 1 edge, then ready_i=1 for 1 edge:
  - after the stalled edge, pc_o=0x9000_0004 (branch ignored);
  - after the next edge, pc_o=0xAAAA_BBBB, or 0xAAAA_BBB8 with PC_ALIGN_EN.
- Branch to 0xFFFF_FFFC, then one sequential edge -> pc_o=0x0000_0000 (wrap). Assert rst_i mid-cycle -> pc_o=BOOT_ADDR before the next clock edge.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch-stage program counter: holds the current fetch address, advances by 4
// per accepted handshake or redirects to a branch target. Optional: PC_ALIGN_EN.
module pc_gen #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ready_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_addr_i,
  output logic        valid_o,
  output logic [31:0] pc_o
);

  logic [31:0] tgt;
  logic [31:0] pc_nxt;

`ifdef PC_ALIGN_EN
  // Redirects always land on a word boundary; sequential fetch is unaffected.
  assign tgt = {branch_target_addr_i[31:2], 2'b00};
`else
  assign tgt = branch_target_addr_i;
`endif

  // A branch seen during a stall is dropped; it only takes effect if still
  // asserted on the edge where ready_i is high.
  always_comb begin
    pc_nxt = pc_o;
    if (ready_i) begin
      if (branch_taken_i) pc_nxt = tgt;
      else                pc_nxt = pc_o + 32'd4;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_o    <= BOOT_ADDR;
      valid_o <= 1'b0;
    end else begin
      pc_o    <= pc_nxt;
      valid_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed-vector bench for pc_gen with hand-computed expected PCs.
module tb_pc_gen;

  localparam logic [31:0] BOOT = 32'h8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ready_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_addr_i;
  logic        valid_o;
  logic [31:0] pc_o;

  int n_vec  = 0;
  int n_miss = 0;

  pc_gen #(.BOOT_ADDR(BOOT)) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .ready_i              (ready_i),
    .valid_o              (valid_o),
    .branch_taken_i       (branch_taken_i),
    .branch_target_addr_i (branch_target_addr_i),
    .pc_o                 (pc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic edge1();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic br, input logic [31:0] tgt);
    ready_i              = rdy;
    branch_taken_i       = br;
    branch_target_addr_i = tgt;
  endtask

  logic [31:0] odd_exp;

  initial begin
`ifdef PC_ALIGN_EN
    odd_exp = 32'hAAAA_BBB8;
`else
    odd_exp = 32'hAAAA_BBBB;
`endif
    rst_i = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    #1;
    chk("rst_pc_async",    pc_o, BOOT);
    chk("rst_valid_async", {31'b0, valid_o}, 32'd0);
    edge1();
    edge1();
    chk("rst_pc_hold",    pc_o, BOOT);
    chk("rst_valid_hold", {31'b0, valid_o}, 32'd0);

    rst_i = 1'b0;
    #1;
    chk("rel_valid_pre", {31'b0, valid_o}, 32'd0);
    edge1();
    chk("rel_pc",    pc_o, BOOT);
    chk("rel_valid", {31'b0, valid_o}, 32'd1);

    drive(1'b1, 1'b0, 32'h0);
    edge1(); chk("seq0", pc_o, 32'h8000_0004);
    edge1(); chk("seq1", pc_o, 32'h8000_0008);

    drive(1'b0, 1'b0, 32'h0);
    edge1(); chk("stall0", pc_o, 32'h8000_0008);
    edge1(); chk("stall1", pc_o, 32'h8000_0008);

    drive(1'b1, 1'b1, 32'h9000_0000);
    edge1(); chk("br_tgt", pc_o, 32'h9000_0000);
    drive(1'b1, 1'b0, 32'h1234_5678);
    edge1(); chk("br_seq", pc_o, 32'h9000_0004);

    drive(1'b0, 1'b1, 32'hAAAA_BBBB);
    edge1(); chk("br_stalled", pc_o, 32'h9000_0004);
    drive(1'b1, 1'b1, 32'hAAAA_BBBB);
    edge1(); chk("br_odd", pc_o, odd_exp);

    drive(1'b1, 1'b1, 32'hFFFF_FFFC);
    edge1(); chk("br_top", pc_o, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 32'h0);
    edge1(); chk("wrap",      pc_o, 32'h0000_0000);
    edge1(); chk("wrap_next", pc_o, 32'h0000_0004);
    chk("valid_run", {31'b0, valid_o}, 32'd1);

    // Mid-cycle reset must act before the next edge.
    drive(1'b1, 1'b1, 32'h5555_0000);
    #2;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_pc",    pc_o, BOOT);
    chk("mid_rst_valid", {31'b0, valid_o}, 32'd0);
    edge1();
    chk("mid_rst_hold", pc_o, BOOT);
    rst_i = 1'b0;
    drive(1'b1, 1'b0, 32'h0);
    edge1();
    chk("resume_pc",    pc_o, 32'h8000_0004);
    chk("resume_valid", {31'b0, valid_o}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
